// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad, debounces presses/releases and
// strobes the hex code of each newly accepted key.
module keypad_scanner #(
    parameter int SCAN_DIV        = 24000,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    output logic       key_held_o
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    state_t state_q, state_d;
    logic [3:0] row_m_q, row_s_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] col_q, col_d, key_q, key_d;
    logic [1:0] r_q, r_d;
    logic valid_q, valid_d, held_q, held_d;
    logic [3:0] col_next;
    logic [1:0] c_idx, row_low;
    logic hit;
    assign col_next = {col_q[2:0], col_q[3]};
    assign c_idx = col_q[1] ? 2'd1 : col_q[2] ? 2'd2 : col_q[3] ? 2'd3 : 2'd0;
    assign row_low = row_s_q[0] ? 2'd0 : row_s_q[1] ? 2'd1 : row_s_q[2] ? 2'd2 : 2'd3;
    assign hit = row_s_q[r_q];
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        key_d   = key_q;
        r_d     = r_q;
        valid_d = 1'b0;
        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (|row_s_q) begin
                        state_d = DEBOUNCE;
                        r_d     = row_low;
                        cnt_d   = '0;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!hit) begin
                    state_d = SCAN;
                    col_d   = col_next;
                    dwell_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    key_d   = KEY_MAP[{r_q, c_idx, 2'b00} +: 4];
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!hit) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (hit) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = SCAN;
                    col_d   = col_next;
                    dwell_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
        held_d = (state_d == HELD) || (state_d == RELEASE);
    end
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= SCAN;
            row_m_q <= '0;
            row_s_q <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            col_q   <= 4'b0001;
            key_q   <= 4'h0;
            r_q     <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_m_q <= row_i;
            row_s_q <= row_m_q;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            key_q   <= key_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end
    assign col_o       = col_q;
    assign key_o       = key_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized checks of keypad_scanner against a behavioural model.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] row = 4'h0;
    logic [3:0] col, key;
    logic key_valid, key_held;
    int checks = 0;
    int errors = 0;
    int vcount = 0;
    int codes [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    always #5 clk = ~clk;
    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk_i(clk), .reset_i(reset), .row_i(row),
        .col_o(col), .key_o(key), .key_valid_o(key_valid), .key_held_o(key_held)
    );
    logic [3:0] p0, p1, rs, m_col, m_key;
    int ci, dwell, run, r;
    bit cand, acc, live, m_valid, m_held, prev_v;
    always @(posedge clk) begin
        rs = p1;
        p1 = p0;
        p0 = row;
        m_valid = 1'b0;
        if (!reset) begin
            p0 = 0; p1 = 0; ci = 0; dwell = 0; run = 0; r = 0;
            cand = 0; acc = 0; m_key = 0; live = 1;
        end else if (!cand) begin
            if (dwell == SD - 1) begin
                dwell = 0;
                if (rs != 0) begin
                    cand = 1;
                    run = 0;
                    for (int i = 3; i >= 0; i--) if (rs[i]) r = i;
                end else ci = (ci + 1) % 4;
            end else dwell++;
        end else if (!acc) begin
            if (!rs[r]) begin
                cand = 0; ci = (ci + 1) % 4; dwell = 0;
            end else if (run + 1 == DB) begin
                acc = 1; run = 0; m_key = 4'(codes[r * 4 + ci]); m_valid = 1'b1;
            end else run++;
        end else begin
            if (rs[r]) run = 0;
            else if (run == DB) begin
                acc = 0; cand = 0; ci = (ci + 1) % 4; dwell = 0;
            end else run++;
        end
        m_col = 4'b0001 << ci;
        m_held = acc;
    end
    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_%s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) if (live) begin
        chk("col", col, m_col);
        chk("key", key, m_key);
        chk("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
        chk("key_held", {3'b0, key_held}, {3'b0, m_held});
        checks++;
        if (key_valid && prev_v) begin
            errors++;
            $display("FAIL valid_twice: key_valid high two cycles in a row at %0t", $time);
        end
        prev_v = key_valid;
        if (key_valid) vcount++;
    end
    task automatic tick;
        @(negedge clk);
        #1;
    endtask
    task automatic lit(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic wait_col(logic [3:0] t);
        int n = 0;
        while (col !== t && n < 200) begin tick; n++; end
        lit("wait_col", int'(col), int'(t));
    endtask
    task automatic wait_valid(output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < 200) begin tick; n++; end
        lit("wait_valid", int'(key_valid), 1);
    endtask
    task automatic wait_release(output int n);
        n = 0;
        while (key_held !== 1'b0 && n < 200) begin tick; n++; end
        lit("wait_release", int'(key_held), 0);
    endtask
    initial begin
        int n, v0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            lit("scan_col", int'(col), 1 << ((i / 4) % 4));
            lit("scan_idle", int'({key_valid, key_held, key}), 0);
        end
        wait_col(4'b0010);
        row = 4'b0100;
        wait_valid(n);
        lit("press_latency", n, 12);
        lit("press_key", int'(key), 8);
        lit("press_col", int'(col), 2);
        lit("press_held", int'(key_held), 1);
        repeat (5) tick;
        lit("hold_col", int'(col), 2);
        row = 4'b0101;
        v0 = vcount;
        repeat (12) tick;
        lit("same_row_no_strobe", vcount - v0, 0);
        lit("same_row_key", int'(key), 8);
        lit("same_row_col", int'(col), 2);
        row = 4'b0000;
        wait_release(n);
        lit("release_latency", n, 11);
        lit("release_col", int'(col), 4);
        lit("release_key", int'(key), 8);
        wait_col(4'b1000);
        v0 = vcount;
        row = 4'b1000;
        repeat (3) tick;
        row = 4'b0000;
        wait_col(4'b0001);
        lit("bounce_no_strobe", vcount - v0, 0);
        lit("bounce_key", int'(key), 8);
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++) begin
                wait_col(4'b0001 << cc);
                v0 = vcount;
                row = 4'b0001 << rr;
                wait_valid(n);
                lit("map_key", int'(key), codes[rr * 4 + cc]);
                row = 4'b0000;
                wait_release(n);
                lit("map_one_strobe", vcount - v0, 1);
            end
        wait_col(4'b0010);
        row = 4'b0010;
        wait_valid(n);
        lit("hold5_key", int'(key), 5);
        repeat (3) tick;
        reset = 1'b0;
        tick;
        lit("rst_col", int'(col), 1);
        lit("rst_rest", int'({key_valid, key_held, key}), 0);
        reset = 1'b1;
        row = 4'b0000;
        repeat (250) begin
            row = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                tick;
                reset = 1'b1;
            end
            repeat ($urandom_range(1, 25)) tick;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
